pipeline_controller: RTL and testbench
======================================

PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 SHALL have parameter REG_ADDR_WIDTH, default 5, register-address width.
REQ-002 SHALL have parameter CNT_WIDTH, default 32, performance-counter width.
REQ-003 SHALL have parameter MEM_TIMEOUT, default 255, consecutive memBusy cycles before timeout flag.
REQ-004 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rstn  in  1  asynchronous, active-low reset.
- decRs1Addr, decRs2Addr  in  REG_ADDR_WIDTH  source registers of the instruction in Decode.
- decRs1Used, decRs2Used  in  1  source actually read.
- exIsLoad  in  1  Execute instruction is a load.
- exRdWrite  in  1  Execute instruction writes rd.
- exRdAddr  in  REG_ADDR_WIDTH  Execute destination.
- exBranchMiss  in  1  misprediction resolved in Execute.
- exIsHalt  in  1  halt instruction in Execute.
- memBusy  in  1  data memory not ready; MemoryAccess must hold.
- stallF, stallD, stallE, stallM  out  1  hold that stage's pipe register.
- flushD, flushE  out  1  load bubble into Decode/Execute pipe register.
- pcWriteEnable  out  1  PC may update.
- halted  out  1  core stopped.
- memTimeout  out  1  sticky memory-timeout error.
- stallCycles, flushCount  out  CNT_WIDTH  performance counters.

Function
REQ-005 SHALL implement FSM RUN, DRAIN, HALTED; reset state RUN.
REQ-006 Load-use hazard SHALL be exIsLoad & exRdWrite & exRdAddr!=0 & ((decRs1Used & decRs1Addr==exRdAddr) | (decRs2Used & decRs2Addr==exRdAddr)).
REQ-007 Stall/flush outputs SHALL be combinational from state and same-cycle inputs; priority memBusy > exBranchMiss > exIsHalt > load-use.
REQ-008 RUN, memBusy=1: stallF=stallD=stallE=stallM=1, flushD=flushE=0, pcWriteEnable=0.
REQ-009 RUN, exBranchMiss (no memBusy): flushD=flushE=1, all stalls 0, pcWriteEnable=1 (redirect).
REQ-010 RUN, exIsHalt (no memBusy, no miss): stallF=stallD=1, flushE=1, pcWriteEnable=0; next state DRAIN with drain counter=2.
REQ-011 RUN, load-use only: stallF=stallD=1, flushE=1, pcWriteEnable=0; released next cycle once Execute holds the bubble.
REQ-012 RUN, no condition: all stalls/flushes 0, pcWriteEnable=1.
REQ-013 DRAIN: stallF=stallD=1, flushE=1, pcWriteEnable=0; counter decrements when memBusy=0; memBusy additionally asserts stallE, stallM and freezes counter; at counter 0 go HALTED. exBranchMiss and exIsHalt ignored.
REQ-014 HALTED: all stalls 1, flushes 0, pcWriteEnable=0, halted=1 (registered, state==HALTED); only reset exits.
REQ-015 stallCycles SHALL increment each cycle stallF=1 in RUN or DRAIN; flushCount SHALL increment each cycle flushD=1; both saturate at all-ones.
REQ-016 memWaitCnt SHALL count consecutive memBusy cycles, clear when memBusy=0, saturate at MEM_TIMEOUT; reaching MEM_TIMEOUT sets memTimeout, held until reset.

Reset
REQ-017 rstn low SHALL immediately force state RUN, drain counter 0, memWaitCnt 0, stallCycles 0, flushCount 0, halted 0, memTimeout 0; combinational outputs then follow RUN rules.
REQ-018 Reset asserted mid-DRAIN or mid-memBusy SHALL abandon the operation with no residual stall.

Structure
REQ-019 ControllerState enum and PipelineCtrl struct (stall/flush/pcWriteEnable bundle) SHALL reside in PipelineTypes; MEM_TIMEOUT default in BasicTypes.
REQ-020 Load-use comparison SHALL be sub-module load_use_detector (combinational).

Verification
REQ-021 exIsLoad=1, exRdWrite=1, exRdAddr=5, decRs1Used=1, decRs1Addr=5 -> stallF=stallD=flushE=1 for 1 cycle; stallCycles +1.
REQ-022 Same with exRdAddr=0 -> no stall, pcWriteEnable=1.
REQ-023 exBranchMiss=1 with load-use present -> flushD=flushE=1, stallF=0; flushCount +1.
REQ-024 exIsHalt=1, memBusy=1 on first DRAIN cycle -> halted rises 4 cycles after halt (1 issue + 1 frozen + 2 drain).
REQ-025 memBusy held 255 cycles, MEM_TIMEOUT=255 -> memTimeout=1 on cycle 255, stays 1 after memBusy drops until rstn.
REQ-026 rstn low during DRAIN -> state RUN, counters 0, pcWriteEnable=1 immediately.

Source files
------------

// File: rtl/pipeline_controller_pkg.sv
// ---------------------------------------------------------------------------
// Shared types for the pipeline controller.
//   BasicTypes    : default widths and the memory-timeout threshold.
//   PipelineTypes : controller FSM state, the stall/flush/PC-enable bundle
//                   and the fixed control patterns the controller selects from.
// No ports; imported by pipeline_controller.
// ---------------------------------------------------------------------------
package BasicTypes;
    localparam int REG_ADDR_WIDTH_DEFAULT = 5;
    localparam int CNT_WIDTH_DEFAULT      = 32;
    localparam int MEM_TIMEOUT_DEFAULT    = 255;
endpackage

package PipelineTypes;
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } ControllerState;

    // Instructions still ahead of the halt that must retire before stopping.
    localparam int         DRAIN_CNT_WIDTH = 2;
    localparam logic [1:0] DRAIN_CYCLES    = 2'd2;

    typedef struct packed {
        logic stallF;
        logic stallD;
        logic stallE;
        logic stallM;
        logic flushD;
        logic flushE;
        logic pcWriteEnable;
    } PipelineCtrl;

    // Free-running pipe: everything advances, PC updates.
    localparam PipelineCtrl CTRL_FREE = '{stallF: 1'b0, stallD: 1'b0, stallE: 1'b0,
        stallM: 1'b0, flushD: 1'b0, flushE: 1'b0, pcWriteEnable: 1'b1};
    // Whole pipe frozen (memory wait or halted core).
    localparam PipelineCtrl CTRL_HOLD_ALL = '{stallF: 1'b1, stallD: 1'b1, stallE: 1'b1,
        stallM: 1'b1, flushD: 1'b0, flushE: 1'b0, pcWriteEnable: 1'b0};
    // Front end held, bubble injected into Execute.
    localparam PipelineCtrl CTRL_BUBBLE = '{stallF: 1'b1, stallD: 1'b1, stallE: 1'b0,
        stallM: 1'b0, flushD: 1'b0, flushE: 1'b1, pcWriteEnable: 1'b0};
    // Mispredict: squash Decode and Execute, let PC take the redirect target.
    localparam PipelineCtrl CTRL_REDIRECT = '{stallF: 1'b0, stallD: 1'b0, stallE: 1'b0,
        stallM: 1'b0, flushD: 1'b1, flushE: 1'b1, pcWriteEnable: 1'b1};
endpackage

// File: rtl/pipeline_controller_load_use_detector.sv
// ---------------------------------------------------------------------------
// load_use_detector: flags a load in Execute whose destination is read by the
// instruction currently in Decode. Purely combinational.
// Ports:
//   dec_rs1_addr/dec_rs2_addr  in  Decode source register addresses
//   dec_rs1_used/dec_rs2_used  in  source actually read
//   ex_is_load, ex_rd_write    in  Execute instruction is a load writing rd
//   ex_rd_addr                 in  Execute destination register
//   load_use                   out hazard present this cycle
// ---------------------------------------------------------------------------
module load_use_detector #(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic [REG_ADDR_WIDTH-1:0] dec_rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] dec_rs2_addr,
    input  logic                      dec_rs1_used,
    input  logic                      dec_rs2_used,
    input  logic                      ex_is_load,
    input  logic                      ex_rd_write,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
    output logic                      load_use
);

    logic rd_live;
    logic rs1_match;
    logic rs2_match;

    // Register 0 is hardwired, so a load targeting it never creates a hazard.
    assign rd_live   = ex_is_load & ex_rd_write & (ex_rd_addr != '0);
    assign rs1_match = dec_rs1_used & (dec_rs1_addr == ex_rd_addr);
    assign rs2_match = dec_rs2_used & (dec_rs2_addr == ex_rd_addr);
    assign load_use  = rd_live & (rs1_match | rs2_match);

endmodule

// File: rtl/pipeline_controller.sv
// ---------------------------------------------------------------------------
// pipeline_controller: hazard/stall/flush control for a 5-stage pipeline,
// with halt draining, memory-timeout detection and performance counters.
// Ports:
//   clk, rstn                    clock (rising edge), async active-low reset
//   decRs1Addr/decRs2Addr        Decode source registers
//   decRs1Used/decRs2Used        Decode source actually read
//   exIsLoad, exRdWrite, exRdAddr Execute load / destination info
//   exBranchMiss, exIsHalt       Execute misprediction / halt
//   memBusy                      data memory not ready
//   stallF/D/E/M, flushD/E       per-stage hold / bubble (combinational)
//   pcWriteEnable                PC may update (combinational)
//   halted                       core stopped (registered)
//   memTimeout                   sticky memory-timeout error
//   stallCycles, flushCount      saturating performance counters
// ---------------------------------------------------------------------------
module pipeline_controller
    import BasicTypes::*;
    import PipelineTypes::*;
#(
    parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEFAULT,
    parameter int CNT_WIDTH      = CNT_WIDTH_DEFAULT,
    parameter int MEM_TIMEOUT    = MEM_TIMEOUT_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [REG_ADDR_WIDTH-1:0] decRs1Addr,
    input  logic [REG_ADDR_WIDTH-1:0] decRs2Addr,
    input  logic                      decRs1Used,
    input  logic                      decRs2Used,
    input  logic                      exIsLoad,
    input  logic                      exRdWrite,
    input  logic [REG_ADDR_WIDTH-1:0] exRdAddr,
    input  logic                      exBranchMiss,
    input  logic                      exIsHalt,
    input  logic                      memBusy,
    output logic                      stallF,
    output logic                      stallD,
    output logic                      stallE,
    output logic                      stallM,
    output logic                      flushD,
    output logic                      flushE,
    output logic                      pcWriteEnable,
    output logic                      halted,
    output logic                      memTimeout,
    output logic [CNT_WIDTH-1:0]      stallCycles,
    output logic [CNT_WIDTH-1:0]      flushCount
);

    localparam int WAIT_WIDTH = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_WIDTH-1:0] WAIT_LIMIT = WAIT_WIDTH'(MEM_TIMEOUT);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX    = '1;

    ControllerState              state;
    logic [DRAIN_CNT_WIDTH-1:0]  drain_cnt;
    logic [WAIT_WIDTH-1:0]       mem_wait_cnt;
    logic [WAIT_WIDTH-1:0]       mem_wait_next;
    logic                        load_use;
    PipelineCtrl                 ctrl;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] value);
        return (value == CNT_MAX) ? value : value + CNT_WIDTH'(1);
    endfunction

    load_use_detector #(
        .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
    ) u_load_use (
        .dec_rs1_addr(decRs1Addr),
        .dec_rs2_addr(decRs2Addr),
        .dec_rs1_used(decRs1Used),
        .dec_rs2_used(decRs2Used),
        .ex_is_load  (exIsLoad),
        .ex_rd_write (exRdWrite),
        .ex_rd_addr  (exRdAddr),
        .load_use    (load_use)
    );

    // Stall/flush selection; priority memBusy > exBranchMiss > exIsHalt > load-use.
    always_comb begin
        ctrl = CTRL_FREE;
        unique case (state)
            RUN: begin
                if (memBusy)                 ctrl = CTRL_HOLD_ALL;
                else if (exBranchMiss)       ctrl = CTRL_REDIRECT;
                else if (exIsHalt)           ctrl = CTRL_BUBBLE;
                else if (load_use)           ctrl = CTRL_BUBBLE;
                else                         ctrl = CTRL_FREE;
            end
            DRAIN: begin
                // Older instructions keep retiring; a memory wait freezes them too.
                ctrl        = CTRL_BUBBLE;
                ctrl.stallE = memBusy;
                ctrl.stallM = memBusy;
            end
            HALTED:  ctrl = CTRL_HOLD_ALL;
            default: ctrl = CTRL_FREE;
        endcase
    end

    assign stallF        = ctrl.stallF;
    assign stallD        = ctrl.stallD;
    assign stallE        = ctrl.stallE;
    assign stallM        = ctrl.stallM;
    assign flushD        = ctrl.flushD;
    assign flushE        = ctrl.flushE;
    assign pcWriteEnable = ctrl.pcWriteEnable;

    // Consecutive-busy run length, saturating at the timeout threshold.
    always_comb begin
        mem_wait_next = '0;
        if (memBusy) begin
            mem_wait_next = (mem_wait_cnt == WAIT_LIMIT) ? mem_wait_cnt
                                                          : mem_wait_cnt + WAIT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= RUN;
            drain_cnt    <= '0;
            mem_wait_cnt <= '0;
            stallCycles  <= '0;
            flushCount   <= '0;
            halted       <= 1'b0;
            memTimeout   <= 1'b0;
        end else begin
            mem_wait_cnt <= mem_wait_next;
            if (memBusy && (mem_wait_next == WAIT_LIMIT)) memTimeout <= 1'b1;

            if (ctrl.stallF && (state != HALTED)) stallCycles <= sat_inc(stallCycles);
            if (ctrl.flushD)                      flushCount  <= sat_inc(flushCount);

            unique case (state)
                RUN: begin
                    if (!memBusy && !exBranchMiss && exIsHalt) begin
                        state     <= DRAIN;
                        drain_cnt <= DRAIN_CYCLES;
                    end
                end
                DRAIN: begin
                    // Leave on the cycle the last draining instruction retires,
                    // so halted is visible the cycle the counter would read 0.
                    if (!memBusy) begin
                        if (drain_cnt <= DRAIN_CNT_WIDTH'(1)) begin
                            state     <= HALTED;
                            drain_cnt <= '0;
                            halted    <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt - DRAIN_CNT_WIDTH'(1);
                        end
                    end
                end
                HALTED:  halted <= 1'b1;
                default: state  <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_controller.sv
module tb_pipeline_controller;
    localparam int RAW = 5;
    localparam int CW  = 32;
    localparam int MT  = 255;
    localparam longint CNT_TOP = (64'sd1 <<< CW) - 1;

    localparam int M_RUN   = 0;
    localparam int M_DRAIN = 1;
    localparam int M_HALT  = 2;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic [RAW-1:0] decRs1Addr = '0, decRs2Addr = '0, exRdAddr = '0;
    logic decRs1Used = 0, decRs2Used = 0, exIsLoad = 0, exRdWrite = 0;
    logic exBranchMiss = 0, exIsHalt = 0, memBusy = 0;
    logic stallF, stallD, stallE, stallM, flushD, flushE, pcWriteEnable;
    logic halted, memTimeout;
    logic [CW-1:0] stallCycles, flushCount;

    always #5 clk = ~clk;

    pipeline_controller #(
        .REG_ADDR_WIDTH(RAW),
        .CNT_WIDTH(CW),
        .MEM_TIMEOUT(MT)
    ) dut (
        .clk(clk), .rstn(rstn),
        .decRs1Addr(decRs1Addr), .decRs2Addr(decRs2Addr),
        .decRs1Used(decRs1Used), .decRs2Used(decRs2Used),
        .exIsLoad(exIsLoad), .exRdWrite(exRdWrite), .exRdAddr(exRdAddr),
        .exBranchMiss(exBranchMiss), .exIsHalt(exIsHalt), .memBusy(memBusy),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE), .pcWriteEnable(pcWriteEnable),
        .halted(halted), .memTimeout(memTimeout),
        .stallCycles(stallCycles), .flushCount(flushCount)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model
    int     m_mode;
    int     m_drain_left;
    longint m_stall;
    longint m_flush;
    int     m_wait;
    bit     m_timeout;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic bit hazard();
        return exIsLoad && exRdWrite && (exRdAddr != 0) &&
               ((decRs1Used && decRs1Addr == exRdAddr) || (decRs2Used && decRs2Addr == exRdAddr));
    endfunction

    // {stallF, stallD, stallE, stallM, flushD, flushE, pcWriteEnable}
    function automatic logic [6:0] expected_ctrl();
        if (m_mode == M_HALT)  return 7'b1111_000;
        if (m_mode == M_DRAIN) return {1'b1, 1'b1, memBusy, memBusy, 1'b0, 1'b1, 1'b0};
        if (memBusy)           return 7'b1111_000;
        if (exBranchMiss)      return 7'b0000_111;
        if (exIsHalt || hazard()) return 7'b1100_010;
        return 7'b0000_001;
    endfunction

    task automatic model_reset();
        m_mode = M_RUN; m_drain_left = 0; m_stall = 0; m_flush = 0; m_wait = 0; m_timeout = 0;
    endtask

    task automatic model_advance();
        logic [6:0] ec;
        ec = expected_ctrl();
        if (ec[6] && m_mode != M_HALT && m_stall < CNT_TOP) m_stall++;
        if (ec[2] && m_flush < CNT_TOP) m_flush++;
        if (memBusy) begin
            if (m_wait < MT) m_wait++;
            if (m_wait == MT) m_timeout = 1;
        end else begin
            m_wait = 0;
        end
        if (m_mode == M_RUN) begin
            if (!memBusy && !exBranchMiss && exIsHalt) begin
                m_mode = M_DRAIN;
                m_drain_left = 2;
            end
        end else if (m_mode == M_DRAIN) begin
            if (!memBusy) begin
                m_drain_left--;
                if (m_drain_left == 0) m_mode = M_HALT;
            end
        end
    endtask

    task automatic compare_all();
        check("ctrl", {stallF, stallD, stallE, stallM, flushD, flushE, pcWriteEnable}, expected_ctrl());
        check("halted", halted, (m_mode == M_HALT));
        check("memTimeout", memTimeout, m_timeout);
        check("stallCycles", stallCycles, m_stall);
        check("flushCount", flushCount, m_flush);
    endtask

    task automatic step(input bit busy, input bit miss, input bit halt, input bit load,
                        input bit rdw, input int rd, input int rs1, input int rs2,
                        input bit u1, input bit u2);
        @(negedge clk);
        memBusy = busy; exBranchMiss = miss; exIsHalt = halt;
        exIsLoad = load; exRdWrite = rdw; exRdAddr = rd[RAW-1:0];
        decRs1Addr = rs1[RAW-1:0]; decRs2Addr = rs2[RAW-1:0];
        decRs1Used = u1; decRs2Used = u2;
        #1;
        compare_all();
        if (rstn) model_advance();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rand_step(input bit allow_halt);
        step($urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
             allow_halt && ($urandom_range(0, 29) == 0),
             $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        memBusy = 0; exBranchMiss = 0; exIsHalt = 0; exIsLoad = 0; exRdWrite = 0;
        exRdAddr = '0; decRs1Addr = '0; decRs2Addr = '0; decRs1Used = 0; decRs2Used = 0;
        #1;
        model_reset();
        compare_all();
        check("rst_pcwe", pcWriteEnable, 1'b1);
        check("rst_stallF", stallF, 1'b0);
        check("rst_stallCycles", stallCycles, 0);
        check("rst_halted", halted, 1'b0);
        @(negedge clk);
        #1;
        compare_all();
        rstn = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1);
    end

    initial begin
        model_reset();
        do_reset();

        // Load-use on rs1
        step(0, 0, 0, 1, 1, 5, 5, 0, 1, 0);
        check("lu_stallF", stallF, 1'b1);
        check("lu_stallD", stallD, 1'b1);
        check("lu_flushE", flushE, 1'b1);
        check("lu_pcwe", pcWriteEnable, 1'b0);
        idle();
        check("lu_released", stallF, 1'b0);
        check("lu_stallCycles", stallCycles, 1);
        // Destination x0 is not a hazard
        step(0, 0, 0, 1, 1, 0, 0, 0, 1, 0);
        check("x0_stallF", stallF, 1'b0);
        check("x0_pcwe", pcWriteEnable, 1'b1);
        // Mispredict beats load-use
        step(0, 1, 0, 1, 1, 5, 5, 0, 1, 0);
        check("miss_flushD", flushD, 1'b1);
        check("miss_flushE", flushE, 1'b1);
        check("miss_stallF", stallF, 1'b0);
        idle();
        check("miss_flushCount", flushCount, 1);
        check("miss_stallCycles", stallCycles, 1);

        for (int i = 0; i < 400; i++) rand_step(0);

        // Memory timeout
        do_reset();
        for (int i = 0; i < 254; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("to_before", memTimeout, 1'b0);
        idle();
        check("to_set", memTimeout, 1'b1);
        for (int i = 0; i < 3; i++) idle();
        check("to_sticky", memTimeout, 1'b1);

        // Halt with a memory wait on the first drain cycle
        do_reset();
        step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        check("halt_issue_stallF", stallF, 1'b1);
        check("halt_issue_flushE", flushE, 1'b1);
        check("halt_issue_pcwe", pcWriteEnable, 1'b0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("drain_busy_stallE", stallE, 1'b1);
        check("drain_h1", halted, 1'b0);
        idle();
        check("drain_h2", halted, 1'b0);
        idle();
        check("drain_h3", halted, 1'b0);
        idle();
        check("drain_h4", halted, 1'b1);
        check("halted_stallM", stallM, 1'b1);
        for (int i = 0; i < 20; i++) rand_step(1);

        // Reset mid-drain
        do_reset();
        step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle();
        check("drain_mid_stallF", stallF, 1'b1);
        do_reset();
        idle();
        check("post_rst_stallF", stallF, 1'b0);
        check("post_rst_pcwe", pcWriteEnable, 1'b1);

        // Random traffic with halts and occasional resets
        for (int i = 0; i < 1500; i++) begin
            if ((m_mode == M_HALT && $urandom_range(0, 7) == 0) ||
                (m_mode == M_DRAIN && $urandom_range(0, 3) == 0))
                do_reset();
            else
                rand_step(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
